// File: rtl/store_narrower.sv
// Narrows a 32-bit SB/SH/SW store into big-endian byte writes; 1 byte/cycle, done 1 cycle after last byte.
// Backpressure: mem_ready low holds the current byte; illegal/misaligned requests skip straight to done.
module store_narrower #(
  parameter int dataBits = 32,
  parameter int addrBits = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [dataBits-1:0] data,
  input  logic [addrBits-1:0] addr,
  input  logic [1:0]          size,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [addrBits-1:0] mem_addr,
  output logic [7:0]          mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t              r_state;
  logic [1:0]          r_idx;
  logic [1:0]          r_last;
  logic [dataBits-1:0] r_data;
  logic [addrBits-1:0] r_addr;
  logic                r_mis;
  logic                r_mem_we;
  logic [addrBits-1:0] r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic                r_busy;
  logic                r_done;
  logic                r_misaligned;

  state_t              w_nxt_state;
  logic [1:0]          w_nxt_idx;
  logic [1:0]          w_nxt_last;
  logic [dataBits-1:0] w_nxt_data;
  logic [addrBits-1:0] w_nxt_addr;
  logic                w_nxt_mis;
  logic                w_illegal;
  logic [1:0]          w_req_last;
  logic [1:0]          w_byte_sel;
  logic [7:0]          w_sel_byte;
  logic                w_in_write;

  always_comb begin
    w_illegal  = 1'b0;
    w_req_last = 2'd0;
    case (size)
      2'b00: begin w_illegal = 1'b0;          w_req_last = 2'd0; end
      2'b01: begin w_illegal = addr[0];       w_req_last = 2'd1; end
      2'b10: begin w_illegal = |addr[1:0];    w_req_last = 2'd3; end
      default: begin w_illegal = 1'b1;        w_req_last = 2'd0; end
    endcase
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_last  = r_last;
    w_nxt_data  = r_data;
    w_nxt_addr  = r_addr;
    w_nxt_mis   = r_mis;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_data  = data;
          w_nxt_addr  = addr;
          w_nxt_idx   = 2'd0;
          w_nxt_last  = w_req_last;
          w_nxt_mis   = w_illegal;
          w_nxt_state = w_illegal ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          if (r_idx == r_last) w_nxt_state = S_DONE;
          else                 w_nxt_idx   = r_idx + 2'd1;
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Big-endian: the first byte written is the most significant byte of the operand slice.
  always_comb begin
    w_byte_sel = w_nxt_last - w_nxt_idx;
    w_sel_byte = 8'h00;
    case (w_byte_sel)
      2'd0: w_sel_byte = w_nxt_data[7:0];
      2'd1: w_sel_byte = w_nxt_data[15:8];
      2'd2: w_sel_byte = w_nxt_data[23:16];
      default: w_sel_byte = w_nxt_data[31:24];
    endcase
  end

  assign w_in_write = (w_nxt_state == S_WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_last       <= 2'd0;
      r_data       <= '0;
      r_addr       <= '0;
      r_mis        <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'h00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_idx        <= w_nxt_idx;
      r_last       <= w_nxt_last;
      r_data       <= w_nxt_data;
      r_addr       <= w_nxt_addr;
      r_mis        <= w_nxt_mis;
      r_mem_we     <= w_in_write;
      r_mem_addr   <= w_in_write ? (w_nxt_addr + addrBits'(w_nxt_idx)) : '0;
      r_mem_wdata  <= w_in_write ? w_sel_byte : 8'h00;
      r_busy       <= (w_nxt_state != S_IDLE);
      r_done       <= (w_nxt_state == S_DONE);
      r_misaligned <= (w_nxt_state == S_DONE) && w_nxt_mis;
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_store_narrower.sv
// Scoreboard bench for store_narrower: expected writes/dones queued at issue, checked as the DUT emits them.
module tb_store_narrower;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  typedef struct {
    logic m;
    int   c;
  } dn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        misaligned;

  wr_t wq[$];
  dn_t dq[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_err = 0;
  int  n_done = 0;
  int  n_done_exp = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  store_narrower #(.dataBits(32), .addrBits(32)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .addr(addr),
    .size(size), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .misaligned(misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},   {31'd0, mem_we},     32'd0);
    chk({tag, "_busy"}, {31'd0, busy},       32'd0);
    chk({tag, "_done"}, {31'd0, done},       32'd0);
    chk({tag, "_mis"},  {31'd0, misaligned}, 32'd0);
    chk({tag, "_addr"}, mem_addr,            32'd0);
    chk({tag, "_wdat"}, {24'd0, mem_wdata},  32'd0);
  endtask

  // stall[k] = 1 drops mem_ready in cycle k; rst_k != 0 pulses reset low in that cycle.
  task automatic store(input logic [31:0] d, input logic [31:0] a, input logic [1:0] s,
                       input logic [7:0] stall, input bit restart, input int rst_k);
    int          t0;
    int          k;
    int          last;
    int          done_k;
    bit          bad;
    logic [31:0] tmp;
    wr_t         w;
    dn_t         dn;
    @(posedge clk); #1;
    t0        = cyc;
    start     = 1'b1;
    data      = d;
    addr      = a;
    size      = s;
    mem_ready = 1'($urandom_range(0, 1));
    bad  = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    last = (s == 2'b00) ? 0 : (s == 2'b01) ? 1 : 3;
    k = 1;
    if (!bad) begin
      for (int i = 0; i <= last; i++) begin
        while (k < 8 && stall[k]) k++;
        tmp = d >> (8 * (last - i));
        w.a = a + 32'(i);
        w.d = tmp[7:0];
        w.c = t0 + k;
        if (rst_k == 0 || k < rst_k) wq.push_back(w);
        k++;
      end
    end
    done_k = k;
    if (rst_k == 0) begin
      dn.m = bad;
      dn.c = t0 + done_k;
      dq.push_back(dn);
      n_done_exp++;
    end
    for (int kk = 1; kk <= 7; kk++) begin
      @(posedge clk); #1;
      start     = restart && (kk <= 2);
      data      = $urandom;
      addr      = $urandom;
      size      = 2'($urandom_range(0, 3));
      mem_ready = !stall[kk];
      if (kk == 1 && rst_k != 1) chk("busy_rise", {31'd0, busy}, 32'd1);
      if (rst_k == 0 && kk == done_k + 1) chk("busy_fall", {31'd0, busy}, 32'd0);
      if (kk == rst_k) begin
        reset = 1'b0;
        #1;
        chk_all_zero("rst_mid");
      end else begin
        reset = 1'b1;
      end
    end
    start     = 1'b0;
    mem_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (!done) chk("mis_no_done", {31'd0, misaligned}, 32'd0);
      if (mem_we) begin
        chk("we_expected", {31'd0, (wq.size() != 0)}, 32'd1);
        if (wq.size() != 0) begin
          chk("wr_addr", mem_addr, wq[0].a);
          chk("wr_data", {24'd0, mem_wdata}, {24'd0, wq[0].d});
          if (mem_ready) begin
            chk("wr_cycle", cyc, wq[0].c);
            void'(wq.pop_front());
          end
        end
      end
      if (done) begin
        n_done++;
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_we", {31'd0, mem_we}, 32'd0);
        chk("done_expected", {31'd0, (dq.size() != 0)}, 32'd1);
        if (dq.size() != 0) begin
          chk("done_mis", {31'd0, misaligned}, {31'd0, dq[0].m});
          chk("done_cycle", cyc, dq[0].c);
          void'(dq.pop_front());
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    data      = 32'd0;
    addr      = 32'd0;
    size      = 2'b00;
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("in_reset");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk_all_zero("idle");
    end

    store(32'h11223344, 32'h0000_0100, 2'b10, 8'b0000_0000, 1'b0, 0);
    store(32'hDEADBEEF, 32'h0000_0202, 2'b01, 8'b0000_0010, 1'b0, 0);
    store(32'h12345678, 32'h0000_0203, 2'b01, 8'b0000_0000, 1'b0, 0);
    store(32'h12345678, 32'h0000_0102, 2'b10, 8'b0000_0000, 1'b0, 0);
    store(32'h12345678, 32'h0000_0100, 2'b11, 8'b0000_0000, 1'b0, 0);
    store(32'h000000A5, 32'hFFFF_FFFF, 2'b00, 8'b0000_0000, 1'b1, 0);
    store(32'hCAFEF00D, 32'h0000_0400, 2'b10, 8'b0000_0000, 1'b0, 3);
    store(32'h01020304, 32'h0000_0500, 2'b10, 8'b0000_0100, 1'b0, 0);
    store(32'h0000BEEF, 32'h0000_0600, 2'b00, 8'b0000_0010, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("wq_empty", wq.size(), 32'd0);
    chk("dq_empty", dq.size(), 32'd0);
    chk("done_count", n_done, n_done_exp);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
